// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipe_reg_chain register pipeline.
//   occ_w(depth)  : width of an occupancy count able to hold 0..depth
//   pipe_stage_t  : one pipeline slot {vld, dat}. Shown here at the default
//                   data width; modules with their own WIDTH declare a local
//                   struct of the same {vld, dat[WIDTH-1:0]} shape.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int unsigned PIPE_WIDTH_DEF = 32;

   function automatic int unsigned occ_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   typedef struct packed {
      logic                      vld;
      logic [PIPE_WIDTH_DEF-1:0] dat;
   } pipe_stage_t;

endpackage

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One WIDTH-bit register slot with a valid bit: the wide form of the
// enable/clear flop.
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset (highest priority)
//   clr     in   synchronous flush
//   ld      in   load this slot this cycle (already qualified by enable)
//   in_vld  in   valid bit of the incoming beat
//   in_dat  in   data of the incoming beat
//   vld_q   out  slot valid
//   dat_q   out  slot data
// Data is only written when the incoming beat is valid, so bubbles passing
// through leave the data register untouched.
// -----------------------------------------------------------------------------
module pipe_stage #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ld,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_dat,
   output logic             vld_q,
   output logic [WIDTH-1:0] dat_q
);

   typedef struct packed {
      logic             vld;
      logic [WIDTH-1:0] dat;
   } stage_t;

   stage_t st_q, st_d;

   always_comb begin
      st_d = st_q;
      if (ld) begin
         st_d.vld = in_vld;
         if (in_vld) begin
            st_d.dat = in_dat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q <= '0;
      end else if (clr) begin
         st_q <= '0;
      end else begin
         st_q <= st_d;
      end
   end

   assign vld_q = st_q.vld;
   assign dat_q = st_q.dat;

endmodule

// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
// DEPTH-stage, WIDTH-bit register pipeline with ready/valid backpressure and
// bubble squeezing: empty stages always accept, so upstream stalls only when
// every stage is full and downstream is not taking the output beat.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   clr      in   synchronous flush of all in-flight beats
//   en       in   global advance enable (0 freezes every stage)
//   s_valid  in   upstream beat valid
//   s_data   in   upstream beat data
//   s_ready  out  chain accepts s_data this cycle
//   m_valid  out  output beat valid (last stage)
//   m_data   out  output beat data (last stage)
//   m_ready  in   downstream accepts the output beat
//   occ      out  registered count of valid stages (PIPE_OCC_EN only)
// Build option: define PIPE_OCC_EN to add the occ port and its counter.
// -----------------------------------------------------------------------------
module pipe_reg_chain
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready
`ifdef PIPE_OCC_EN
   ,
   output logic [occ_w(DEPTH)-1:0] occ
`endif
);

   logic [DEPTH-1:0]            vld_q;
   logic [DEPTH-1:0][WIDTH-1:0] dat_q;
   logic [DEPTH:0]              go;
   logic                        flush;

   assign flush = rst | clr;

   // Readiness ripples from the output back to the input: a stage may load
   // when it is empty or when the stage after it is loading this cycle.
   always_comb begin
      int unsigned idx;
      idx        = 0;
      go         = '0;
      go[DEPTH]  = m_ready;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx     = DEPTH - 1 - k;
         go[idx] = en & (~vld_q[idx] | go[idx+1]);
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .ld     (go[g]),
            .in_vld (s_valid),
            .in_dat (s_data),
            .vld_q  (vld_q[g]),
            .dat_q  (dat_q[g])
         );
      end else begin : g_body
         pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .ld     (go[g]),
            .in_vld (vld_q[g-1]),
            .in_dat (dat_q[g-1]),
            .vld_q  (vld_q[g]),
            .dat_q  (dat_q[g])
         );
      end
   end

   assign s_ready = go[0] & ~flush;
   assign m_valid = vld_q[DEPTH-1] & ~flush;
   assign m_data  = flush ? '0 : dat_q[DEPTH-1];

`ifdef PIPE_OCC_EN
   localparam int unsigned OW = occ_w(DEPTH);

   logic [OW-1:0] occ_q, occ_d;
   logic          in_xfer, out_xfer;

   assign in_xfer  = s_valid & s_ready;
   assign out_xfer = m_valid & m_ready & en;

   always_comb begin
      occ_d = occ_q;
      if (in_xfer && !out_xfer) begin
         occ_d = occ_q + OW'(1);
      end else if (!in_xfer && out_xfer) begin
         occ_d = occ_q - OW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else if (clr) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occ = occ_q;
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;

   localparam int unsigned W = 8;
   localparam int unsigned D = 3;

   logic         clk = 1'b0;
   logic         rst, clr, en, s_valid, s_ready, m_valid, m_ready;
   logic [W-1:0] s_data, m_data;
`ifdef PIPE_OCC_EN
   logic [pipe_pkg::occ_w(D)-1:0] occ;
`endif

   always #5 clk = ~clk;

   pipe_reg_chain #(.WIDTH(W), .DEPTH(D)) dut (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .en      (en),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_ready (m_ready)
`ifdef PIPE_OCC_EN
      ,
      .occ     (occ)
`endif
   );

   int           n_chk  = 0;
   int           n_pass = 0;
   logic [W-1:0] exp_q[$];   // beats accepted and not yet delivered, in order
   logic [W-1:0] pend[$];
   logic         acc;

   task automatic chk(input string name, input int act, input int expv);
      n_chk++;
      if (act == expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
   endtask

   // One clock cycle: drive at the falling edge, check combinational outputs
   // 1 time unit later, then update the in-flight model. Stage positions are
   // irrelevant to the model: the chain accepts unless it is frozen, flushed,
   // or holds DEPTH beats with downstream not taking one.
   task automatic cycle(input logic sv, input logic [W-1:0] sd, input logic mr,
                        input logic e, input logic c, input logic r, output logic a);
      logic exp_rdy;
      @(negedge clk);
      s_valid = sv; s_data = sd; m_ready = mr; en = e; clr = c; rst = r;
      #1;
      exp_rdy = !r && !c && e && ((exp_q.size() < D) || mr);
      chk("s_ready", int'(s_ready), int'(exp_rdy));
`ifdef PIPE_OCC_EN
      if (!r) chk("occ", int'(occ), exp_q.size());
`endif
      if (r || c) begin
         chk("flush_m_valid", int'(m_valid), 0);
         chk("flush_m_data", int'(m_data), 0);
         exp_q.delete();
      end
      a = sv && exp_rdy;
      if (a) exp_q.push_back(sd);
   endtask

   // Monitor: pops the scoreboard on every output transfer and checks that a
   // presented-but-unaccepted beat stays put until it is taken.
   initial begin
      logic         held;
      logic [W-1:0] hd;
      held = 1'b0;
      hd   = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst || clr) begin
            held = 1'b0;
         end else begin
`ifdef PIPE_OCC_EN
            assert (occ <= D && int'(occ) == $countones(dut.vld_q))
               else $error("occ %0d inconsistent with stage valids", occ);
`endif
            if (held) begin
               chk("hold_m_valid", int'(m_valid), 1);
               chk("hold_m_data", int'(m_data), int'(hd));
            end
            if (m_valid && m_ready && en) begin
               if (exp_q.size() == 0) chk("spurious_beat", int'(m_valid), 0);
               else chk("out_data", int'(m_data), int'(exp_q.pop_front()));
            end
            held = m_valid && !(m_ready && en);
            hd   = m_data;
         end
      end
   end

   task automatic drain(input string name);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, acc);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, acc);
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; en = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

      // reset state
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
      chk("reset_m_valid", int'(m_valid), 0);
      chk("reset_m_data", int'(m_data), 0);

      // back-to-back beats into an empty chain: DEPTH-cycle latency, 1 beat/cycle
      for (int t = 0; t < 7; t++) begin
         cycle(t < 3, W'(8'h11 * (t + 1)), 1'b1, 1'b1, 1'b0, 1'b0, acc);
         chk("lat_m_valid", int'(m_valid), int'(t >= 3 && t <= 5));
      end

      // stalled output: chain fills to DEPTH then backpressures; release drains in order
      pend = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
      for (int t = 0; t < 6; t++) begin
         cycle(pend.size() != 0, (pend.size() != 0) ? pend[0] : '0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
         if (acc) void'(pend.pop_front());
      end
      for (int k = 0; k < 30 && (pend.size() != 0 || exp_q.size() != 0); k++) begin
         cycle(pend.size() != 0, (pend.size() != 0) ? pend[0] : '0, 1'b1, 1'b1, 1'b0, 1'b0, acc);
         if (acc) void'(pend.pop_front());
      end
      chk("stall_drain", exp_q.size() + pend.size(), 0);

      // gap between beats, then freeze with en=0
      cycle(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b0, acc);
      cycle(1'b0, '0,    1'b0, 1'b1, 1'b0, 1'b0, acc);
      cycle(1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, acc);
      cycle(1'b0, '0,    1'b0, 1'b1, 1'b0, 1'b0, acc);
      cycle(1'b0, '0,    1'b0, 1'b1, 1'b0, 1'b0, acc);
      for (int t = 0; t < 4; t++) cycle(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b0, acc);
      drain("freeze_drain");

      // full chain, clr with a beat offered
      for (int t = 0; t < 3; t++) cycle(1'b1, W'(8'hC0 + t), 1'b0, 1'b1, 1'b0, 1'b0, acc);
      cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, acc);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
      chk("clr_m_valid_after", int'(m_valid), 0);
      drain("clr_drain");

      // full chain, reset mid-stream
      for (int t = 0; t < 3; t++) cycle(1'b1, W'(8'hD0 + t), 1'b0, 1'b1, 1'b0, 1'b0, acc);
      cycle(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0, 1'b1, acc);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
      chk("rst_m_valid_after", int'(m_valid), 0);
      chk("rst_m_data_after", int'(m_data), 0);
      drain("rst_drain");

      // randomized traffic
      for (int t = 0; t < 2000; t++) begin
         cycle(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0), 1'b0, acc);
      end
      drain("random_drain");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
